nabp_shift_accumulator: RTL and testbench

//  Reads the angle-indexed shift-accumulation base from the NABP shifter LUT and

---
 rtl/nabp_shift_accumulator.sv | 116 +++++++++++
 tb/tb_nabp_shift_accumulator.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/nabp_shift_accumulator.sv
// Per-angle shift accumulator: looks up the NABP base once per job, emits floor(k*base) per line.
// Optional NABP_SHIFT_ROUND_EN selects round-half-up instead of floor; latency/handshake unchanged.
module nabp_shift_accumulator #(
   parameter int ANGLE_W   = 8,
   parameter int BASE_W    = 16,
   parameter int FRAC_W    = 8,
   parameter int NUM_LINES = 16,
   parameter int SHIFT_W   = 12,
   localparam int LINE_W   = (NUM_LINES > 1) ? $clog2(NUM_LINES) : 1
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      start,
   input  logic [ANGLE_W-1:0]        angle,
   output logic                      busy,
   output logic                      err_angle,
   output logic [ANGLE_W-1:0]        sh_angle,
   input  logic signed [BASE_W-1:0]  sh_accu_base,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic signed [SHIFT_W-1:0] out_shift,
   output logic [LINE_W-1:0]         out_line,
   output logic                      out_last
);

   localparam int ACC_W = BASE_W + LINE_W;
   localparam logic [LINE_W-1:0] LAST = LINE_W'(NUM_LINES - 1);

   typedef enum logic [2:0] {S_IDLE, S_LOOKUP, S_WAIT, S_RUN, S_DONE} state_t;

   state_t                   state;
   logic signed [BASE_W-1:0] base;
   logic signed [ACC_W-1:0]  accu;
   logic signed [ACC_W-1:0]  accu_nxt;
   logic [LINE_W-1:0]        cnt;

   assign accu_nxt = accu + ACC_W'(base);
   assign out_line = cnt;

   // Fixed point accumulator to integer shift; the rounded build needs one guard bit for the bias.
   function automatic logic signed [SHIFT_W-1:0] to_shift(input logic signed [ACC_W-1:0] a);
`ifdef NABP_SHIFT_ROUND_EN
      logic signed [ACC_W:0] r;
      logic signed [ACC_W:0] s;
      r = {a[ACC_W-1], a} + ((ACC_W+1)'(1) << (FRAC_W - 1));
      s = r >>> FRAC_W;
      return SHIFT_W'(s);
`else
      logic signed [ACC_W-1:0] s;
      s = a >>> FRAC_W;
      return SHIFT_W'(s);
`endif
   endfunction

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= S_IDLE;
         busy      <= 1'b0;
         err_angle <= 1'b0;
         sh_angle  <= '0;
         base      <= '0;
         accu      <= '0;
         cnt       <= '0;
         out_valid <= 1'b0;
         out_shift <= '0;
         out_last  <= 1'b0;
      end else begin
         err_angle <= 1'b0;
         case (state)
            S_IDLE: begin
               if (start) begin
                  if (32'(angle) < 32'd180) begin
                     sh_angle <= angle;
                     busy     <= 1'b1;
                     state    <= S_LOOKUP;
                  end else begin
                     err_angle <= 1'b1;
                  end
               end
            end
            S_LOOKUP: state <= S_WAIT;
            S_WAIT: begin
               // Base is latched exactly once; later LUT activity is ignored for this job.
               base      <= sh_accu_base;
               accu      <= '0;
               cnt       <= '0;
               out_shift <= '0;
               out_valid <= 1'b1;
               out_last  <= (NUM_LINES == 1);
               state     <= S_RUN;
            end
            S_RUN: begin
               if (out_ready) begin
                  accu <= accu_nxt;
                  if (cnt == LAST) begin
                     out_valid <= 1'b0;
                     out_last  <= 1'b0;
                     state     <= S_DONE;
                  end else begin
                     cnt       <= cnt + LINE_W'(1);
                     out_shift <= to_shift(accu_nxt);
                     out_last  <= ((cnt + LINE_W'(1)) == LAST);
                  end
               end
            end
            S_DONE: begin
               busy  <= 1'b0;
               cnt   <= '0;
               state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_nabp_shift_accumulator.sv
// Randomized scoreboard bench for nabp_shift_accumulator with an arithmetic reference model.
module tb_nabp_shift_accumulator;
   localparam int N  = 4;
   localparam int SW = 12;

   logic              clk = 1'b0;
   logic              reset = 1'b0;
   logic              start = 1'b0;
   logic [7:0]        angle = '0;
   logic              busy, err_angle;
   logic [7:0]        sh_angle;
   logic signed [15:0] sh_accu_base;
   logic              out_valid;
   logic              out_ready = 1'b1;
   logic signed [SW-1:0] out_shift;
   logic [1:0]        out_line;
   logic              out_last;

   nabp_shift_accumulator #(
      .ANGLE_W(8), .BASE_W(16), .FRAC_W(8), .NUM_LINES(N), .SHIFT_W(SW)
   ) dut (
      .clk(clk), .reset(reset), .start(start), .angle(angle), .busy(busy),
      .err_angle(err_angle), .sh_angle(sh_angle), .sh_accu_base(sh_accu_base),
      .out_valid(out_valid), .out_ready(out_ready), .out_shift(out_shift),
      .out_line(out_line), .out_last(out_last)
   );

   always #5 clk = ~clk;

   // Registered LUT: data follows sh_angle by one clock.
   logic [15:0] lut [0:255];
   always @(posedge clk) sh_accu_base <= lut[sh_angle];

   typedef struct packed {
      logic signed [SW-1:0] shift;
      logic [1:0]           line;
      logic                 last;
   } exp_t;

   exp_t sb[$];
   int total = 0;
   int bad = 0;
   int ready_mode = 0;

   task automatic check(input string name, input logic signed [31:0] act, input logic signed [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic fail(input string name);
      total++;
      bad++;
      $display("FAIL %s: condition not met", name);
   endtask

   // Line k shift = floor(k*base / 2^8), or floor((k*base + 128) / 2^8) when rounding.
   function automatic int exp_shift(input int b, input int k);
      int v, q;
      v = b * k;
`ifdef NABP_SHIFT_ROUND_EN
      v = v + 128;
`endif
      q = v / 256;
      if (v < 0 && (v % 256) != 0) q = q - 1;
      return q;
   endfunction

   task automatic push_job(input logic [7:0] a);
      exp_t e;
      int b;
      b = int'($signed(lut[a]));
      for (int k = 0; k < N; k++) begin
         e.shift = SW'(exp_shift(b, k));
         e.line  = 2'(k);
         e.last  = (k == N - 1);
         sb.push_back(e);
      end
   endtask

   // Monitor: pops on each handshake, and requires held outputs while stalled.
   exp_t        cur;
   logic        held = 1'b0;
   logic [14:0] saved;
   always @(negedge clk) begin
      if (reset) begin
         held = 1'b0;
      end else if (out_valid) begin
         if (held) check("stall_hold", {out_shift, out_line, out_last}, saved);
         if (out_ready) begin
            held = 1'b0;
            if (sb.size() == 0) begin
               fail("unexpected_word");
            end else begin
               cur = sb.pop_front();
               check("shift", out_shift, cur.shift);
               check("line", out_line, cur.line);
               check("last", out_last, cur.last);
            end
         end else begin
            held  = 1'b1;
            saved = {out_shift, out_line, out_last};
         end
      end else begin
         if (held) fail("valid_dropped_in_stall");
         held = 1'b0;
      end
   end

   // out_ready driver: 0 tied high, 1 pattern 1,0,0, 2 random.
   initial begin
      int ph;
      ph = 0;
      forever begin
         @(posedge clk);
         #1;
         case (ready_mode)
            1: begin
               out_ready = (ph == 0);
               ph = (ph + 1) % 3;
            end
            2: out_ready = 1'($urandom_range(0, 1));
            default: out_ready = 1'b1;
         endcase
      end
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic run_job(input logic [7:0] a, input int rmode, input bit inject, input bit chk_timing);
      int n;
      ready_mode = rmode;
      push_job(a);
      start = 1'b1;
      angle = a;
      tick;
      start = 1'b0;
      angle = 8'($urandom);
      n = 0;
      while (!out_valid && n < 20) begin
         tick;
         n++;
      end
      if (!out_valid) fail("first_valid_timeout");
      else check("first_valid_latency", n + 1, 3);
      while (busy && n < 300) begin
         if (n == 3 && inject) begin
            start = 1'b1;
            angle = 8'($urandom_range(0, 179));
         end else begin
            start = 1'b0;
         end
         if (n == 4) lut[a] = 16'($urandom);
         tick;
         n++;
      end
      start = 1'b0;
      if (busy) fail("job_end_timeout");
      else if (chk_timing) check("job_cycles", n + 1, N + 4);
      check("sh_angle_kept", sh_angle, a);
      check("scoreboard_drained", sb.size(), 0);
      ready_mode = 0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] prev;
      int n;
      logic [7:0] a;
      for (int i = 0; i < 256; i++) lut[i] = 16'($urandom);
      lut[30] = 16'h0180;
      lut[31] = 16'hFE80;

      #2 reset = 1'b1;
      #20 reset = 1'b0;
      #2;
      check("rst_busy", busy, 0);
      check("rst_err", err_angle, 0);
      check("rst_valid", out_valid, 0);
      check("rst_last", out_last, 0);
      check("rst_sh_angle", sh_angle, 0);
      check("rst_shift", out_shift, 0);
      check("rst_line", out_line, 0);

      tick;
      run_job(8'd30, 0, 1'b0, 1'b1);
      run_job(8'd31, 0, 1'b0, 1'b1);
      lut[30] = 16'h0180;
      lut[31] = 16'hFE80;
      run_job(8'd30, 1, 1'b0, 1'b0);
      run_job(8'd31, 1, 1'b1, 1'b0);

      // Out-of-range angle in IDLE.
      tick;
      prev  = sh_angle;
      start = 1'b1;
      angle = 8'(180 + $urandom_range(0, 75));
      tick;
      start = 1'b0;
      check("err_pulse", err_angle, 1);
      check("err_busy", busy, 0);
      check("err_sh_angle", sh_angle, prev);
      tick;
      check("err_pulse_end", err_angle, 0);
      check("err_no_valid", out_valid, 0);

      // Reset in the middle of a job, with line 2 on the output.
      a = 8'd77;
      push_job(a);
      start = 1'b1;
      angle = a;
      tick;
      start = 1'b0;
      n = 0;
      while (!out_valid && n < 20) begin
         tick;
         n++;
      end
      tick;
      tick;
      check("pre_reset_line", out_line, 2);
      reset = 1'b1;
      #1;
      check("reset_valid_drop", out_valid, 0);
      check("reset_busy_drop", busy, 0);
      sb.delete();
      tick;
      #3 reset = 1'b0;
      tick;
      run_job(a, 0, 1'b0, 1'b1);

      for (int j = 0; j < 12; j++) begin
         int rm;
         rm = $urandom_range(0, 2);
         run_job(8'($urandom_range(0, 179)), rm, 1'($urandom_range(0, 1)), rm == 0);
         repeat ($urandom_range(0, 3)) tick;
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
